// File: rtl/vote_pkg.sv
// Shared types and constants for the ballot session controller.
// Holds the session state enum, ballot class encodings and class weights.
package vote_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_OPEN  = 2'b01,
        S_DRAIN = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        CLS_BLANK = 2'b00,
        CLS_NP    = 2'b01,
        CLS_VIP   = 2'b10,
        CLS_VVIP  = 2'b11
    } cls_t;

    localparam int DEFAULT_NUM_BOOTH = 4;
    localparam int WEIGHT_W          = 5;

    localparam logic [WEIGHT_W-1:0] W_BLANK = 5'd0;
    localparam logic [WEIGHT_W-1:0] W_NP    = 5'd1;
    localparam logic [WEIGHT_W-1:0] W_VIP   = 5'd4;
    localparam logic [WEIGHT_W-1:0] W_VVIP  = 5'd16;

    function automatic logic [WEIGHT_W-1:0] class_weight(input logic [1:0] c);
        logic [WEIGHT_W-1:0] w;
        case (cls_t'(c))
            CLS_NP:   w = W_NP;
            CLS_VIP:  w = W_VIP;
            CLS_VVIP: w = W_VVIP;
            default:  w = W_BLANK;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the lowest eligible index at or above
// the pointer wins, wrapping around modulo NUM_BOOTH.
module rr_arbiter #(
    parameter  int NUM_BOOTH = 4,
    localparam int PTR_W     = (NUM_BOOTH > 1) ? $clog2(NUM_BOOTH) : 1
) (
    input  logic [NUM_BOOTH-1:0] eligible,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_BOOTH-1:0] winner,
    output logic                 valid
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NUM_BOOTH; k++) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_BOOTH);
            if (!valid && eligible[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vote_session_ctrl.sv
// Ballot session controller: session FSM, round-robin booth grants and a
// saturating weighted tally shared by all booths.
module vote_session_ctrl
    import vote_pkg::*;
#(
    parameter  int NUM_BOOTH = DEFAULT_NUM_BOOTH,
    parameter  int TALLY_W   = 8,
    localparam int PTR_W     = (NUM_BOOTH > 1) ? $clog2(NUM_BOOTH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic [NUM_BOOTH-1:0]   req,
    input  logic [2*NUM_BOOTH-1:0] cls,
    output logic [NUM_BOOTH-1:0]   gnt,
    output logic [TALLY_W-1:0]     tally,
    output logic                   ovf,
    output logic                   busy,
    output logic                   done
);

    localparam int SUM_W = ((TALLY_W > WEIGHT_W) ? TALLY_W : WEIGHT_W) + 1;
    localparam logic [TALLY_W-1:0] TALLY_MAX = {TALLY_W{1'b1}};

    state_t               state, state_next;
    logic [PTR_W-1:0]     ptr, ptr_next;
    logic [NUM_BOOTH-1:0] eligible, winner;
    logic                 valid;
    logic                 grant_en;
    logic                 session_clear;
    logic [1:0]           win_cls;
    logic [WEIGHT_W-1:0]  weight;
    logic [SUM_W-1:0]     sum;
    logic                 sat;

    // A booth just granted is masked out so it cannot win twice in a row.
    assign eligible = req & ~gnt;

    rr_arbiter #(.NUM_BOOTH(NUM_BOOTH)) u_arb (
        .eligible (eligible),
        .ptr      (ptr),
        .winner   (winner),
        .valid    (valid)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_OPEN;
            S_OPEN:  if (stop)  state_next = S_DRAIN;
            S_DRAIN: state_next = S_DONE;
            S_DONE:  if (start) state_next = S_OPEN;
            default: state_next = S_IDLE;
        endcase
    end

    // The edge that leaves OPEN never grants, so pending requests are dropped.
    assign grant_en      = (state == S_OPEN) && !stop && valid;
    assign session_clear = ((state == S_IDLE) || (state == S_DONE)) && start;

    always_comb begin
        ptr_next = ptr;
        win_cls  = 2'b00;
        for (int i = 0; i < NUM_BOOTH; i++) begin
            if (winner[i]) begin
                ptr_next = PTR_W'((i + 1) % NUM_BOOTH);
                win_cls  = cls[2*i +: 2];
            end
        end
    end

    assign weight = class_weight(win_cls);
    assign sum    = SUM_W'(tally) + SUM_W'(weight);
    assign sat    = sum > SUM_W'(TALLY_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            ptr   <= '0;
            gnt   <= '0;
            tally <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            gnt   <= grant_en ? winner : '0;
            if (grant_en) begin
                ptr <= ptr_next;
            end
            if (session_clear) begin
                tally <= '0;
                ovf   <= 1'b0;
            end else if (grant_en) begin
                if (sat) begin
                    tally <= TALLY_MAX;
                    ovf   <= 1'b1;
                end else begin
                    tally <= sum[TALLY_W-1:0];
                end
            end
        end
    end

    assign busy = (state == S_OPEN) || (state == S_DRAIN);
    assign done = (state == S_DONE);

endmodule

// File: doc/vote_session_ctrl.md
VOTE_SESSION_CTRL -- requirements
Module: vote_session_ctrl

Interface
REQ-001 Parameter NUM_BOOTH, default 4: number of ballot booths sharing the tally accumulator.
REQ-002 Parameter TALLY_W, default 8: tally width in bits.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  open a session; level-sampled each cycle.
REQ-006 stop  input  1  close the session; level-sampled each cycle.
REQ-007 req  input  NUM_BOOTH  per-booth ballot request; held high until the booth's gnt is seen.
REQ-008 cls  input  2*NUM_BOOTH  per-booth ballot class, booth i at bits [2i+1:2i]; stable while req[i] is high.
REQ-009 gnt  output  NUM_BOOTH  registered one-hot grant, one cycle per accepted ballot.
REQ-010 tally  output  TALLY_W  registered weighted tally.
REQ-011 ovf  output  1  sticky saturation flag.
REQ-012 busy  output  1  high in OPEN and DRAIN.
REQ-013 done  output  1  high in DONE.

Function
REQ-014 FSM states: IDLE, OPEN, DRAIN, DONE.
REQ-015 IDLE->OPEN on start; OPEN->DRAIN on stop; DRAIN->DONE unconditionally after 1 cycle; DONE->OPEN on start; all other cases hold state.
REQ-016 start in OPEN or DRAIN is ignored; stop outside OPEN is ignored; start and stop together in OPEN: stop wins.
REQ-017 Entering OPEN from IDLE or DONE clears tally and ovf on the same edge.
REQ-018 Class weights: 00 blank = 0, 01 np = 1, 10 vip = 4, 11 vvip = 16; blank ballots are still granted.
REQ-019 Arbitration runs only in OPEN, and not on the edge leaving OPEN; eligible set = req & ~gnt, so a booth is never granted on consecutive cycles.
REQ-020 Round-robin: pointer starts at booth 0; the lowest index at or above the pointer (wrapping modulo NUM_BOOTH) wins; after a grant to booth i the pointer becomes (i+1) mod NUM_BOOTH; with no grant the pointer holds.
REQ-021 At most one grant per cycle; gnt is all-zero outside OPEN, except a grant issued on the final OPEN edge is not permitted (REQ-019), so gnt is zero in DRAIN.
REQ-022 Latency: the winning booth's cls is sampled at the arbitration edge; gnt[i] rises and tally updates on that same edge (tally visible 1 cycle after req seen).
REQ-023 Tally arithmetic is unsigned; tally + weight > 2^TALLY_W-1 saturates tally at all-ones and sets ovf; ovf stays set until the next session clear or reset.
REQ-024 Requests pending when stop is taken are dropped, not queued; tally and ovf hold through DRAIN and DONE.
REQ-025 busy and done are decoded from registered state, with no combinational path from inputs.

Reset
REQ-026 reset asserted: state = IDLE, pointer = 0, gnt = 0, tally = 0, ovf = 0, busy = 0, done = 0, immediately and independent of clk.
REQ-027 reset mid-session discards the partial tally; the block requires a fresh start after release.

Structure
REQ-028 Shared package vote_pkg holds the state enum, class encodings, the weight constants W_NP = 1, W_VIP = 4, W_VVIP = 16, and the default NUM_BOOTH.
REQ-029 One sub-module rr_arbiter (inputs: eligible vector and pointer; outputs: one-hot winner and valid) is instantiated once; the FSM, pointer register and accumulator stay in vote_session_ctrl.

Verification
REQ-030 Reset, then start; booth0 req with cls = 11, then booth1 req with cls = 10 -> gnt 0001 then 0010 on successive edges; tally = 16, then tally = 20.
REQ-031 All four req held continuously with cls = 01 for 8 cycles in OPEN -> grants alternate so no booth twice in a row; after gnt 0001 the next grant is 0010 (pointer rotates); tally increments by 1 on every edge that produces a grant.
REQ-032 Sixteen vvip ballots (256) -> tally = 255, ovf = 1; a further np ballot -> tally stays 255, ovf stays 1; stop, then start -> tally = 0, ovf = 0.
REQ-033 start and stop in the same OPEN cycle while req = 0100 -> state goes to DRAIN, no grant, tally unchanged, done = 1 one cycle later.
REQ-034 reset pulsed asynchronously (between edges) mid-OPEN with tally = 37 -> tally = 0, gnt = 0, busy = 0 before the next clk edge; start is required to resume.
REQ-035 In DONE, req = 1111 for 5 cycles -> gnt stays 0 and tally holds its value.
